result_bcd_scanner: RTL and testbench

Converts the calculator's signed binary result into four BCD digit codes and time-multiplexes them onto a common-anode 4-digit 7-segment display. Sits directly upstream of the BCD-to-7-segment decoder: `bcd_out` drives the decoder's `bcd` input, and `an` drives the display anodes. Conversion is iterative (shift-add-3, one bit per clock). The displayed value is held stable until a new conversion completes.

---
 rtl/result_bcd_scanner_if.sv | 30 +++
 rtl/result_bcd_scanner.sv | 196 +++++++++++++++++++
 tb/tb_result_bcd_scanner.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/result_bcd_scanner_if.sv
// Handshake and display bus of result_bcd_scanner.
// The master drives load/value; the slave returns status and the scan outputs.
interface result_bcd_scanner_if #(
  parameter int DATA_W = 14
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              overflow;
  logic [3:0]        bcd_out;
  logic [3:0]        an;

  modport master (
    output load,
    output value,
    input  busy,
    input  overflow,
    input  bcd_out,
    input  an
  );

  modport slave (
    input  load,
    input  value,
    output busy,
    output overflow,
    output bcd_out,
    output an
  );
endinterface

// File: rtl/result_bcd_scanner.sv
// Signed result -> 4-digit BCD (iterative shift-add-3) with a multiplexed
// common-anode scan. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module result_bcd_scanner #(
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  result_bcd_scanner_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] MINUS = 4'd10;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  iter_reg, iter_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [19:0]       bcd_reg, bcd_next;
  logic [19:0]       bcd_adj;
  logic              neg_reg, neg_next;
  logic              ovf_reg, ovf_next;
  logic              busy_reg, busy_next;
  logic              disp_load;

  logic signed [31:0] val_ext;
  logic [DATA_W-1:0]  mag;
  logic               in_ovf;

  logic [3:0] dig_reg [4];
  logic [3:0] dig_next [4];
  logic [3:0] blank_reg, blank_next;
  logic       overflow_reg;

  logic [REF_W-1:0] ref_reg;
  logic [1:0]       idx_reg;
  logic [3:0]       an_reg;
  logic [3:0]       bcd_out_reg;

  // ---------------------------------------------------------------
  // Input capture helpers
  // ---------------------------------------------------------------
  assign val_ext = {{(32-DATA_W){bus.value[DATA_W-1]}}, bus.value};
  assign mag     = bus.value[DATA_W-1] ? (~bus.value + DATA_W'(1)) : bus.value;
  assign in_ovf  = (val_ext > 32'sd9999) || (val_ext < -32'sd999);

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_reg[gi*4 +: 4] + 4'd3) :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // ---------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
      shift_reg <= '0;
      bcd_reg   <= '0;
      neg_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      shift_reg <= shift_next;
      bcd_reg   <= bcd_next;
      neg_reg   <= neg_next;
      ovf_reg   <= ovf_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    shift_next = shift_reg;
    bcd_next   = bcd_reg;
    neg_next   = neg_reg;
    ovf_next   = ovf_reg;
    busy_next  = 1'b0;
    disp_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          state_next = CONV;
          iter_next  = '0;
          shift_next = mag;
          bcd_next   = '0;
          neg_next   = bus.value[DATA_W-1];
          ovf_next   = in_ovf;
        end
      end
      CONV: begin
        // The final cycle in CONV only commits the result to the display
        if (iter_reg == CNT_W'(DATA_W)) begin
          state_next = IDLE;
          disp_load  = 1'b1;
        end else begin
          busy_next  = 1'b1;
          iter_next  = iter_reg + CNT_W'(1);
          bcd_next   = {bcd_adj[18:0], shift_reg[DATA_W-1]};
          shift_next = {shift_reg[DATA_W-2:0], 1'b0};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Result -> display digit mapping
  // ---------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;

  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (bcd_reg[i*4 +: 4] != 4'd0) msd = 2'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dig_next[i]   = bcd_reg[i*4 +: 4];
      blank_next[i] = (2'(i) > msd);
    end
    if (ovf_reg) begin
      for (int i = 0; i < 4; i++) dig_next[i] = MINUS;
      blank_next = 4'b0000;
    end else if (neg_reg && (msd != 2'd3)) begin
      // Magnitude is at most 999 here, so the sign slot always exists
      dig_next[msd + 2'd1]   = MINUS;
      blank_next[msd + 2'd1] = 1'b0;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dig_next[i] = bcd_reg[i*4 +: 4];
    end
    blank_next = 4'b0000;
    if (ovf_reg) begin
      for (int i = 0; i < 4; i++) dig_next[i] = MINUS;
    end else if (neg_reg) begin
      dig_next[3] = MINUS;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) dig_reg[i] <= 4'd0;
      blank_reg    <= 4'b1110;
      overflow_reg <= 1'b0;
    end else if (disp_load) begin
      for (int i = 0; i < 4; i++) dig_reg[i] <= dig_next[i];
      blank_reg    <= blank_next;
      overflow_reg <= ovf_reg;
    end
  end

  // ---------------------------------------------------------------
  // Refresh scan
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_reg     <= '0;
      idx_reg     <= 2'd0;
      an_reg      <= 4'b1110;
      bcd_out_reg <= 4'd0;
    end else begin
      if (ref_reg == REF_W'(REFRESH_DIV - 1)) begin
        ref_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        ref_reg <= ref_reg + REF_W'(1);
      end
      an_reg      <= blank_reg[idx_reg] ? 4'b1111 : ~(4'b0001 << idx_reg);
      bcd_out_reg <= dig_reg[idx_reg];
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.overflow = overflow_reg;
  assign bus.an       = an_reg;
  assign bus.bcd_out  = bcd_out_reg;

endmodule

// File: tb/tb_result_bcd_scanner.sv
// Directed bench for result_bcd_scanner (DATA_W=14, REFRESH_DIV=4).
// Expected scan patterns follow the LEADING_ZERO_BLANK_EN build setting.
module tb_result_bcd_scanner;

  localparam int DW  = 14;
  localparam int REF = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  result_bcd_scanner_if #(.DATA_W(DW)) bus ();

  result_bcd_scanner #(.DATA_W(DW), .REFRESH_DIV(REF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side cycle count since the last reset edge, used to know the slot
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load(input int v);
    bus.load  = 1'b1;
    bus.value = DW'(v);
    tick();
    bus.load  = 1'b0;
  endtask

  // Checks busy after edges N+1..N+15; optionally pulses load sampled at edge N+pulse_k
  task automatic wait_conv(input string tag, input logic exp_ovf, input int pulse_k, input int pulse_v);
    for (int k = 1; k <= 15; k++) begin
      if (k == pulse_k) begin
        bus.load  = 1'b1;
        bus.value = DW'(pulse_v);
      end
      tick();
      bus.load = 1'b0;
      chk({tag, "_busy"}, {15'd0, bus.busy}, (k <= 14) ? 16'd1 : 16'd0);
    end
    chk({tag, "_ovf"}, {15'd0, bus.overflow}, {15'd0, exp_ovf});
  endtask

  // ean/ebcd hold slot3..slot0 as hex nibbles
  task automatic check_frame(input string tag, input logic [15:0] ean, input logic [15:0] ebcd);
    int slot;
    for (int t = 0; t < 4 * REF; t++) begin
      tick();
      slot = (cyc == 0) ? 0 : ((cyc - 1) / REF) % 4;
      chk({tag, "_an"}, {12'd0, bus.an}, {12'd0, ean[slot*4 +: 4]});
      if (ean[slot*4 +: 4] != 4'hF)
        chk({tag, "_bcd"}, {12'd0, bus.bcd_out}, {12'd0, ebcd[slot*4 +: 4]});
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    tick();
    tick();
    tick();
    reset = 1'b0;

    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_ovf",  {15'd0, bus.overflow}, 16'd0);
    chk("rst_an",   {12'd0, bus.an}, 16'h000E);
    chk("rst_bcd",  {12'd0, bus.bcd_out}, 16'd0);
    check_frame("rst_frame", 16'hFFFE, 16'h0000);

    do_load(1234);
    wait_conv("l1234", 1'b0, 0, 0);
    check_frame("f1234", 16'h7BDE, 16'h1234);

    do_load(-5);
    wait_conv("lm5", 1'b0, 0, 0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("fm5", 16'hFFDE, 16'h00A5);
`else
    check_frame("fm5", 16'h7BDE, 16'hA005);
`endif

    do_load(10000);
    wait_conv("l10000", 1'b1, 0, 0);
    check_frame("f10000", 16'h7BDE, 16'hAAAA);

    do_load(-1000);
    wait_conv("lm1000", 1'b1, 0, 0);
    check_frame("fm1000", 16'h7BDE, 16'hAAAA);

    // load of 3 on the busy-falling edge is dropped; 42 one cycle later is taken
    do_load(7);
    wait_conv("l7", 1'b0, 15, 3);
    do_load(42);
    wait_conv("l42", 1'b0, 5, 99);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("f42", 16'hFFDE, 16'h0042);
`else
    check_frame("f42", 16'h7BDE, 16'h0042);
`endif

    do_load(1234);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("mid_rst_an",   {12'd0, bus.an}, 16'h000E);
    chk("mid_rst_bcd",  {12'd0, bus.bcd_out}, 16'd0);
    check_frame("mid_rst_frame", 16'hFFFE, 16'h0000);
    tick();
    chk("mid_rst_idle", {15'd0, bus.busy}, 16'd0);

    do_load(0);
    wait_conv("l0", 1'b0, 0, 0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("f0", 16'hFFFE, 16'h0000);
`else
    check_frame("f0", 16'h7BDE, 16'h0000);
`endif

    do_load(-999);
    wait_conv("lm999", 1'b0, 0, 0);
    check_frame("fm999", 16'h7BDE, 16'hA999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
